imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 64, instruction-memory depth in 32-bit words.
REQ-002 Parameter: ADDR_W, 6, word-index width, equal to log2(DEPTH).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  reset is asynchronous and active-low.
REQ-005 Port: start  in  1  one-cycle request to begin a load.
REQ-006 Port: rx_data  in  8  incoming program byte.
REQ-007 Port: rx_valid  in  1  rx_data valid.
REQ-008 Port: rx_ready  out  1  loader accepts a byte this cycle.
REQ-009 Port: imem_we  out  1  instruction-memory write strobe.
REQ-010 Port: imem_addr  out  32  word-aligned byte address; imem_addr[1:0] is always 0.
REQ-011 Port: imem_wdata  out  32  instruction word to write.
REQ-012 Port: core_reset  out  1  active-high hold on the core PC/datapath.
REQ-013 Port: busy  out  1  load in progress.
REQ-014 Port: done  out  1  load finished; held until the next start.
REQ-015 Port: err  out  1  load failed; held until the next start.
REQ-016 Port: words_loaded  out  ADDR_W+1  count of words written in the current load.

Function
REQ-017 The FSM SHALL use states IDLE, LEN_LO, LEN_HI, DATA, CSUM (macro only) and DONE.
REQ-018 A byte SHALL transfer only on a rising edge with rx_valid=1 and rx_ready=1.
REQ-019 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in IDLE and DONE.
REQ-020 start SHALL be honored in IDLE or DONE: next state LEN_LO; done, err, words_loaded and the byte counter clear; core_reset=1; busy=1.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 The frame SHALL be a 16-bit word count N, sent low byte then high byte, followed by 4*N data bytes.
REQ-023 If N=0, the next state SHALL be DONE (or CSUM with the macro) with no writes.
REQ-024 If N>DEPTH, the next state SHALL be DONE with err=1, no writes, and no further bytes accepted.
REQ-025 Data bytes SHALL be little-endian: byte k of a word (k=0..3) lands in bits [8k+7:8k].
REQ-026 On the edge that accepts byte 3 of word i, the loader SHALL, in the following cycle, drive imem_we=1 for exactly one cycle, with imem_addr=4*i and imem_wdata equal to the assembled word.
REQ-027 words_loaded SHALL increment on the write cycle.
REQ-028 The byte counter SHALL wrap from 3 to 0; accepting the next byte during the write cycle SHALL be legal, giving zero-bubble throughput.
REQ-029 After the write of word N-1, the loader SHALL enter DONE (or CSUM): busy=0, done=1.
REQ-030 In DONE with err=0, core_reset SHALL deassert; with err=1, core_reset SHALL stay 1.
REQ-031 Between writes, imem_addr and imem_wdata SHALL hold their last values.

Reset
REQ-032 Asserting reset (low) SHALL asynchronously force IDLE with: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, err=0, words_loaded=0.
REQ-033 On reset mid-load, any partially assembled word SHALL be discarded and no write issued; words already written SHALL be left untouched.
REQ-034 After reset release, core_reset SHALL remain 1 until a successful load reaches DONE.

Configuration
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, one trailing byte SHALL be accepted in CSUM.
REQ-036 With IMEM_LOADER_CHECKSUM_EN defined, that trailing byte SHALL equal the XOR of both length bytes and all data bytes; on mismatch, err=1 and core_reset stays 1.
REQ-037 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the XOR register SHALL not exist, and DONE SHALL follow the last write directly.

Structure
REQ-038 Package imem_loader_pkg SHALL hold the state encoding, DEPTH/ADDR_W defaults, and the byte and word width constants.
REQ-039 Sub-module byte_packer SHALL own the byte counter, the 32-bit shift/assemble register and the write-strobe generation; imem_loader owns the FSM and counters.

Verification
REQ-040 Scenario: start, then bytes 04 00 93 00 50 00 13 01 A0 00 B3 81 20 00 23 00 30 00 -> writes (0,00500093), (4,00A00113), (8,002081B3), (C,00300023); done=1; core_reset=0; words_loaded=4.
REQ-041 Scenario: N=0 (bytes 00 00) -> no imem_we; done=1; err=0.
REQ-042 Scenario: N=65 (bytes 41 00) -> err=1; done=1; rx_ready=0; core_reset=1; no writes.
REQ-043 Scenario: frame from REQ-040 with rx_valid toggled 1,0,0,1 per byte -> identical writes; each write exactly one cycle after its 4th byte.
REQ-044 Scenario: reset low after byte 2 of word 1 -> all outputs at reset values; only the write to addr 0 has occurred.
REQ-045 Scenario (macro on): REQ-040 frame plus checksum byte computed per REQ-036 -> err=0; with that checksum byte XORed with 01 -> err=1 and core_reset=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader:
//     - default memory geometry (DEPTH_DEF words, ADDR_W_DEF index bits)
//     - byte / word / length-field width constants
//     - FSM state encoding (state_e)
//     - rx_state(): the states in which the loader accepts bytes
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the ST_CSUM state.
// ----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int DEPTH_DEF      = 64;
  localparam int ADDR_W_DEF     = 6;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_e;

  // States in which a byte may be accepted; busy has the same set.
  function automatic logic rx_state(input state_e s);
    logic r;
    r = 1'b0;
    case (s)
      ST_LEN_LO,
      ST_LEN_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DATA:  r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
//   Assembles little-endian program bytes into 32-bit words and produces a
//   one-cycle instruction-memory write for each completed word.
//
//   Ports:
//     clk, reset     clock, asynchronous active-low reset
//     clear          restart assembly (byte counter and shift register to 0)
//     accept         a data byte transfers on this rising edge
//     byte_in        the data byte
//     word_idx       index of the word currently being assembled
//     byte_cnt       byte position (0..3) of the next byte within its word
//     imem_we        write strobe, high for the cycle after the 4th byte
//     imem_addr      word-aligned byte address (4*word_idx), held between writes
//     imem_wdata     assembled word, held between writes
//
//   Bytes enter at the top of a shift register and move down, so after four
//   bytes byte 0 sits in [7:0] and byte 3 in [31:24]. The counter wraps 3->0
//   on the same edge that launches the write, so the next word's first byte
//   may be accepted during the write cycle.
// ----------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                accept,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic [ADDR_W-1:0]   word_idx,
  output logic [1:0]          byte_cnt,
  output logic                imem_we,
  output logic [WORD_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata
);

  logic [1:0]        cnt_d,   cnt_q;
  logic [WORD_W-1:0] shift_d, shift_q;
  logic              we_d,    we_q;
  logic [WORD_W-1:0] addr_d,  addr_q;
  logic [WORD_W-1:0] wdata_d, wdata_q;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (accept) begin
      shift_d = {byte_in, shift_q[WORD_W-1:BYTE_W]};
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        we_d    = 1'b1;
        addr_d  = WORD_W'({word_idx, 2'b00});
        wdata_d = {byte_in, shift_q[WORD_W-1:BYTE_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Loads a program image from a byte stream into instruction memory while
//   holding the core in reset. Frame: 16-bit word count N (low byte first),
//   then 4*N little-endian data bytes. With IMEM_LOADER_CHECKSUM_EN defined,
//   one trailing byte must equal the XOR of every preceding frame byte.
//
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     start           one-cycle load request, honoured only in IDLE or DONE
//     rx_data/valid   incoming byte stream
//     rx_ready        loader can take a byte this cycle
//     imem_we/addr/wdata  instruction-memory write port
//     core_reset      holds the core; released only by a successful load
//     busy, done, err load status (done/err held until the next start)
//     words_loaded    words written in the current load
//
//   Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
//   are both 1. rx_ready is registered and depends only on loader state, never
//   on rx_valid; the sender may hold rx_valid high with fresh data each cycle.
//
//   The FSM state is kept in state_q (type state_e) for observation.
//   The last data byte moves the FSM to DONE (or CSUM) on the same edge that
//   launches the final write, so that write appears in the first DONE cycle
//   and no extra byte can be taken in between.
// ----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  state_e            state_d, state_q;
  logic [LEN_W-1:0]  len_d, len_q;
  logic [ADDR_W:0]   words_d, words_q;
  logic              rx_ready_d, rx_ready_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              err_d, err_q;
  logic              core_reset_d, core_reset_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_d, xor_q;
`endif

  logic              accept;
  logic              data_accept;
  logic              word_done;
  logic              pack_clear;
  logic [1:0]        byte_cnt;
  logic [LEN_W-1:0]  len_full;

  assign accept      = rx_valid & rx_ready_q;
  assign data_accept = accept && (state_q == ST_DATA);
  assign word_done   = data_accept && (byte_cnt == 2'd3);
  assign len_full    = {rx_data, len_q[BYTE_W-1:0]};

  byte_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .accept     (data_accept),
    .byte_in    (rx_data),
    .word_idx   (words_q[ADDR_W-1:0]),
    .byte_cnt   (byte_cnt),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    done_d       = done_q;
    err_d        = err_q;
    core_reset_d = core_reset_q;
    pack_clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LEN_LO;
          len_d        = '0;
          words_d      = '0;
          done_d       = 1'b0;
          err_d        = 1'b0;
          core_reset_d = 1'b1;
          pack_clear   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d        = '0;
`endif
        end
      end

      ST_LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[LEN_W-1:BYTE_W], rx_data};
          state_d = ST_LEN_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end

      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
          if (len_full > LEN_W'(DEPTH)) begin
            // Oversized image: fail without touching memory or the core.
            state_d      = ST_DONE;
            done_d       = 1'b1;
            err_d        = 1'b1;
            core_reset_d = 1'b1;
          end else if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d      = ST_CSUM;
`else
            state_d      = ST_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (data_accept) begin
          xor_d = xor_q ^ rx_data;
        end
`endif
        if (word_done) begin
          words_d = words_q + 1'b1;
          if ((LEN_W'(words_q) + LEN_W'(1)) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d      = ST_CSUM;
`else
            state_d      = ST_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          err_d        = (rx_data != xor_q);
          core_reset_d = (rx_data != xor_q);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_ready_d = rx_state(state_d);
    busy_d     = rx_state(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      words_q      <= '0;
      rx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      rx_ready_q   <= rx_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign core_reset   = core_reset_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. A reference model turns each byte
//   frame into the list of (address, word) writes and the final status; a
//   monitor matches every imem_we cycle against that list and against the
//   cycle in which the word's fourth byte was accepted.
//   Honours IMEM_LOADER_CHECKSUM_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];     // {addr, data} expected writes, in order
  int          acc_q[$];     // cycle in which each word's 4th byte was accepted
  logic [7:0]  frame_q[$];   // bytes of the frame under test
  logic        exp_err;
  int          exp_words;
  int          exp_nacc;     // bytes the loader is expected to accept
  logic [63:0] mon_e;

  logic [7:0] spec_bytes [18] = '{8'h04, 8'h00,
                                  8'h93, 8'h00, 8'h50, 8'h00,
                                  8'h13, 8'h01, 8'hA0, 8'h00,
                                  8'hB3, 8'h81, 8'h20, 8'h00,
                                  8'h23, 8'h00, 8'h30, 8'h00};

  // Monitor: every write must be expected, in order, one cycle after byte 4.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, mon_e[63:32], mon_e[31:0]);
        end
      end
      checks++;
      if (acc_q.size() == 0 || acc_q[0] != cyc) begin
        errors++;
        $display("FAIL write_latency: write in cycle %0d, required cycle %0d", cyc,
                 (acc_q.size() == 0) ? -1 : acc_q[0]);
      end
      if (acc_q.size() != 0) void'(acc_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  // Derives expected writes and final status from the frame bytes alone.
  task automatic build_expect(input bit push_writes);
    int n;
    logic [31:0] w;
    n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    exp_words = 0;
    exp_err   = 1'b0;
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_nacc = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = 32'(frame_q[2+4*i]) + (32'(frame_q[3+4*i]) << 8) +
            (32'(frame_q[4+4*i]) << 16) + (32'(frame_q[5+4*i]) << 24);
        if (push_writes) exp_q.push_back({32'(4 * i), w});
      end
      exp_words = n;
      exp_nacc  = 2 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int j = 0; j < exp_nacc; j++) x = x ^ frame_q[j];
        exp_err  = (frame_q[exp_nacc] != x);
        exp_nacc = exp_nacc + 1;
      end
`endif
    end
  endtask

  // Appends the trailing checksum byte (XOR of the frame so far, then ^flip).
  task automatic add_csum(input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frame_q[j]) x = x ^ frame_q[j];
    frame_q.push_back(x ^ flip);
`else
    flip = flip;
`endif
  endtask

  task automatic make_frame(input int n, input logic [7:0] flip);
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      add_csum(flip);
    end
  endtask

  task automatic load_spec_frame(input logic [7:0] flip);
    frame_q.delete();
    foreach (spec_bytes[i]) frame_q.push_back(spec_bytes[i]);
    add_csum(flip);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit last4, output bit ok);
    bit rdy;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      rdy = rx_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && last4) acc_q.push_back(cyc);
  endtask

  // Runs one complete load of frame_q and checks the final status.
  // gap_mode: 0 back-to-back, 1 random idle gaps, 2 valid pattern 1,0,0,1.
  task automatic run_frame(input int gap_mode, input bit push_writes, input int glitch_at,
                           input string name);
    bit ok;
    int gap;
    bit last4;
    int t;
    build_expect(push_writes);
    pulse_start();
    checks++;
    if ({busy, rx_ready, core_reset, done, err, words_loaded} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL %s_after_start: got busy/rdy/crst/done/err=%b%b%b%b%b words=%0d, required 11100 words=0",
               name, busy, rx_ready, core_reset, done, err, words_loaded);
    end
    for (int j = 0; j < exp_nacc; j++) begin
      if (j == glitch_at) begin
        rx_valid = 1'b0;
        pulse_start();
      end
      case (gap_mode)
        0:       gap = 0;
        1:       gap = $urandom_range(0, 3);
        default: gap = (j == 0) ? 0 : 2;
      endcase
      last4 = (j >= 2) && (j < 2 + 4 * exp_words) && (((j - 2) % 4) == 3);
      send_byte(frame_q[j], gap, last4, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s_byte_timeout: byte %0d not accepted, required accept", name, j);
        break;
      end
    end
    rx_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    tick();
    tick();
    checks++;
    if ({done, err, core_reset, busy, rx_ready} !== {1'b1, exp_err, exp_err, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_status: got done/err/crst/busy/rdy=%b%b%b%b%b, required 1%b%b00",
               name, done, err, core_reset, busy, rx_ready, exp_err, exp_err);
    end
    checks++;
    if (words_loaded !== 7'(exp_words)) begin
      errors++;
      $display("FAIL %s_words: got %0d, required %0d", name, words_loaded, exp_words);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
    acc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, err, words_loaded} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%h wdata=%h crst=%b busy=%b done=%b err=%b words=%0d, required 0 0 0 0 1 0 0 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, err, words_loaded);
    end
  endtask

  task automatic test_spec_frame();
    load_spec_frame(8'h00);
    exp_q.push_back({32'h0, 32'h00500093});
    exp_q.push_back({32'h4, 32'h00A00113});
    exp_q.push_back({32'h8, 32'h002081B3});
    exp_q.push_back({32'hC, 32'h00300023});
    run_frame(0, 1'b0, -1, "spec_frame");
  endtask

  task automatic test_valid_gaps();
    load_spec_frame(8'h00);
    exp_q.push_back({32'h0, 32'h00500093});
    exp_q.push_back({32'h4, 32'h00A00113});
    exp_q.push_back({32'h8, 32'h002081B3});
    exp_q.push_back({32'hC, 32'h00300023});
    run_frame(2, 1'b0, -1, "valid_gaps");
  endtask

  task automatic test_zero_len();
    make_frame(0, 8'h00);
    run_frame(1, 1'b1, -1, "zero_len");
  endtask

  task automatic test_too_long();
    int bad_ready;
    make_frame(DEPTH + 1, 8'h00);
    run_frame(0, 1'b1, -1, "too_long_65");
    // After an oversized header no further byte may be taken.
    bad_ready = 0;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (4) begin
      if (rx_ready !== 1'b0) bad_ready++;
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (bad_ready != 0 || done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL too_long_hold: got rdy_high_cycles=%0d done=%b err=%b, required 0 1 1",
               bad_ready, done, err);
    end
    make_frame(256 + $urandom_range(0, 1000), 8'h00);
    run_frame(1, 1'b1, -1, "too_long_big");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      make_frame($urandom_range(1, DEPTH), 8'h00);
      run_frame(1, 1'b1, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    make_frame(DEPTH, 8'h00);
    run_frame(0, 1'b1, -1, "back_to_back_full");
    make_frame(1, 8'h00);
    run_frame(0, 1'b1, -1, "single_word");
  endtask

  task automatic test_start_ignored();
    make_frame(3, 8'h00);
    run_frame(1, 1'b1, 7, "start_ignored");
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    make_frame(4, 8'h00);
    build_expect(1'b1);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    pulse_start();
    // Length, all of word 0, then bytes 0..2 of word 1.
    for (int j = 0; j < 9; j++) begin
      send_byte(frame_q[j], 0, (j == 5), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL reset_mid_byte_timeout: byte %0d not accepted, required accept", j);
        break;
      end
    end
    rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    test_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_word0: got %0d outstanding writes, required 0", exp_q.size());
    end
    test_reset();
    acc_q.delete();
  endtask

  task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    load_spec_frame(8'h01);
    run_frame(0, 1'b1, -1, "csum_bad");
    make_frame($urandom_range(1, 8), 8'h80);
    run_frame(1, 1'b1, -1, "csum_bad_rand");
    load_spec_frame(8'h00);
    run_frame(1, 1'b1, -1, "csum_good");
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    tick();
    test_reset();
    test_spec_frame();
    test_valid_gaps();
    test_zero_len();
    test_too_long();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_load();
    test_checksum();
    make_frame($urandom_range(1, 5), 8'h00);
    run_frame(1, 1'b1, -1, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
